// File: rtl/xmem_arbiter.sv
// xmem_arbiter: shares one memory port between instruction fetch (0), core
// data (1) and VLSU data (2). Grants one request per cycle in round-robin
// order. An in-order FIFO stores {source, 32-bit lane} for each outstanding
// request, and each response is routed back to its requester with zero latency.
//
// Ports:
//   clk_i, rst_i                        clock, synchronous active-high reset
//   req_i/addr_i/we_i/be_i/wdata_i      per-requester request fields
//   gnt_o                               one-hot grant (combinational)
//   rvalid_o/rdata_o/err_o              per-requester response (combinational)
//   mem_req_o/mem_gnt_i/mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o
//                                       shared memory request port
//   mem_rvalid_i/mem_err_i/mem_rdata_i  shared memory response port
//   outstanding_o                       FIFO occupancy
//   protocol_err_o                      sticky: response arrived with FIFO empty
module xmem_arbiter #(
  parameter int unsigned MEM_W = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [2:0]                        req_i,
  input  logic [2:0][31:0]                  addr_i,
  input  logic [2:0]                        we_i,
  input  logic [2:0][MEM_W/8-1:0]           be_i,
  input  logic [2:0][MEM_W-1:0]             wdata_i,
  output logic [2:0]                        gnt_o,
  output logic [2:0]                        rvalid_o,
  output logic [2:0][31:0]                  rdata_o,
  output logic [2:0]                        err_o,
  output logic                              mem_req_o,
  input  logic                              mem_gnt_i,
  output logic [31:0]                       mem_addr_o,
  output logic                              mem_we_o,
  output logic [MEM_W/8-1:0]                mem_be_o,
  output logic [MEM_W-1:0]                  mem_wdata_o,
  input  logic                              mem_rvalid_i,
  input  logic                              mem_err_i,
  input  logic [MEM_W-1:0]                  mem_rdata_i,
  output logic [$clog2(DEPTH):0]            outstanding_o,
  output logic                              protocol_err_o
);

  localparam int unsigned LANES     = MEM_W / 32;
  localparam int unsigned LANE_BITS = $clog2(LANES);
  localparam int unsigned LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [31:0] LANE_MASK = (32'd1 << LANE_BITS) - 32'd1;

  logic [1:0]        src_q  [DEPTH];
  logic [LANE_W-1:0] lane_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [1:0]        rr_ptr;

  logic [1:0]        sel, idx, fld;
  logic              found, full, empty, grant, pop;
  logic [LANE_W-1:0] lane_in;
  logic [1:0]        head_src;
  logic [LANE_W-1:0] head_lane;
  logic [MEM_W-1:0]  rdata_sh;

  // Round-robin scan starting at rr_ptr
  always_comb begin
    sel   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      idx = 2'((32'(rr_ptr) + k) % 3);
      if (!found && req_i[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Request path; idle fields come from requester 0 with we forced low
  always_comb begin
    mem_req_o   = !rst_i && found && !full;
    fld         = mem_req_o ? sel : 2'd0;
    mem_addr_o  = addr_i[fld];
    mem_be_o    = be_i[fld];
    mem_wdata_o = wdata_i[fld];
    mem_we_o    = mem_req_o && (sel != 2'd0) && we_i[sel];
    grant       = mem_req_o && mem_gnt_i;
    gnt_o       = 3'b000;
    if (grant) gnt_o[sel] = 1'b1;
    lane_in     = LANE_W'((mem_addr_o >> 2) & LANE_MASK);
  end

  // Response path routed by the FIFO head
  always_comb begin
    head_src  = src_q[rd_ptr];
    head_lane = lane_q[rd_ptr];
    pop       = !rst_i && mem_rvalid_i && !empty;
    rdata_sh  = mem_rdata_i >> (32'(head_lane) * 32);
    rvalid_o  = 3'b000;
    err_o     = 3'b000;
    for (int unsigned i = 0; i < 3; i++) rdata_o[i] = rdata_sh[31:0];
    if (pop) begin
      rvalid_o[head_src] = 1'b1;
      err_o[head_src]    = mem_err_i;
    end
  end

  // Tracking FIFO storage; entries are only meaningful while counted
  always_ff @(posedge clk_i) begin
    if (grant) begin
      src_q[wr_ptr]  <= sel;
      lane_q[wr_ptr] <= lane_in;
    end
  end

  // Pointers, occupancy, round-robin pointer and sticky protocol error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      rr_ptr         <= 2'd0;
      protocol_err_o <= 1'b0;
    end else begin
      if (grant) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rr_ptr <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({grant, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (mem_rvalid_i && empty) protocol_err_o <= 1'b1;
    end
  end

  assign outstanding_o = count;

endmodule

// File: doc/xmem_arbiter.md
# xmem_arbiter

Three-way memory arbiter for the cv32e40x SoC. It shares the single memory port between the core instruction fetch, the core data port and the vector accelerator's VLSU data port. It issues one request per cycle using round-robin priority. An in-order tracking FIFO records the source of each outstanding request, so that each response is routed back to the requester that issued it. It sits in the core wrapper between the three requesters and the memory.

## Interface
Requester index: 0 = instruction fetch, 1 = core data, 2 = VLSU data.

Parameters:
- MEM_W, 32: memory data width; a multiple of 32.
- DEPTH, 8: maximum number of outstanding requests; a power of 2, at least 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  [2:0]  request per requester.
- addr_i  in  [2:0][31:0]  byte address per requester.
- we_i  in  [2:0]  write enable per requester; bit 0 is ignored (fetch is read-only).
- be_i  in  [2:0][MEM_W/8-1:0]  byte enables per requester.
- wdata_i  in  [2:0][MEM_W-1:0]  write data per requester.
- gnt_o  out  [2:0]  grant, one-hot or zero.
- rvalid_o  out  [2:0]  response valid, one-hot or zero.
- rdata_o  out  [2:0][31:0]  response data; 32-bit lane selected by the stored address.
- err_o  out  [2:0]  response error.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory accepts the request this cycle.
- mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o  out  32 / 1 / MEM_W/8 / MEM_W  fields of the selected requester.
- mem_rvalid_i, mem_err_i, mem_rdata_i  in  1 / 1 / MEM_W  memory response.
- outstanding_o  out  $clog2(DEPTH)+1  current FIFO occupancy.
- protocol_err_o  out  1  sticky; set on a response that arrives with the FIFO empty.

## Operation
- Eligibility: requester i is eligible when req_i[i]=1 and count < DEPTH. A grant is never given while the FIFO is full, even if a response pops an entry in the same cycle.
- Selection: round-robin starting at pointer rr_ptr (0..2). The first eligible index scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3) is selected as sel.
- mem_req_o = 1 when any requester is eligible. The mem_* fields come from sel. When mem_req_o = 0, the fields are driven from requester 0 and we = 0.
- Handshake: a grant occurs when mem_req_o & mem_gnt_i. Then gnt_o[sel] = 1, and all other gnt_o bits are 0.
- On a grant:
  - push {sel, addr_i[sel][$clog2(MEM_W/8)-1:2]} into the FIFO;
  - rr_ptr <= (sel+1) mod 3.
- With no grant, rr_ptr holds.
- On mem_rvalid_i with the FIFO non-empty, for head source s and head lane l:
  - pop the FIFO;
  - rvalid_o[s] = 1;
  - err_o[s] = mem_err_i;
  - rdata_o[s] = mem_rdata_i[l*32 +: 32].
- All rdata_o entries carry the lane-selected data every cycle; only rvalid_o qualifies them.
- On mem_rvalid_i with the FIFO empty:
  - no rvalid_o is asserted;
  - protocol_err_o <= 1, and it stays set until reset.
- A push and a pop in the same cycle leave count unchanged; the write and read pointers both advance, modulo DEPTH.
- The block does not reorder responses. Memory must respond in issue order.

## Timing
- gnt_o, mem_req_o and the mem_* fields are combinational from req_i, the mem_* request fields, mem_gnt_i, count and rr_ptr. There are no registers on the request path.
- rvalid_o, rdata_o and err_o are combinational from mem_rvalid_i, the response data and the FIFO head: zero latency.
- Responses can arrive at the earliest 1 cycle after the grant. A response in the grant cycle is not supported; a same-cycle grant and rvalid pop the older entry.
- Throughput: one grant per cycle and one response per cycle, at the same time.
- Reset (rst_i high at a clock edge):
  - count = 0, rd_ptr = wr_ptr = 0, rr_ptr = 0, protocol_err_o = 0;
  - while rst_i is high: gnt_o = 0, mem_req_o = 0, rvalid_o = 0.
- Reset mid-operation discards all outstanding entries. Responses arriving after reset set protocol_err_o.
- outstanding_o = count; its reset value is 0.

## Test plan
- Single fetch: req_i=001, addr 0x80, mem_gnt_i=1 → gnt_o=001, mem_addr_o=0x80, outstanding_o=1. The next cycle, rvalid with rdata 0x12345678 → rvalid_o=001, rdata_o[0]=0x12345678, outstanding_o=0.
- Round-robin: req_i=111 held, mem_gnt_i=1 for 6 cycles, responses delayed → grant order 0,1,2,0,1,2.
- Response routing: grants to 1,2,0 with we=0, then three rvalids with data A,B,C → rvalid_o = 010, 100, 001 with data A, B, C. Inject mem_err_i on the second → err_o=100.
- Full/backpressure: DEPTH=8, 8 grants with no responses → mem_req_o=0 and gnt_o=000 while req_i=111. After one rvalid, the next cycle grants again. A cycle with full FIFO and rvalid gives no grant in that cycle.
- Stall: mem_gnt_i=0 with req_i=100 → gnt_o=000, rr_ptr unchanged, mem_addr_o=addr_i[2] held stable, no push.
- Lane select with MEM_W=64:
  - fetch at 0x84, rdata 0xAAAAAAAA_BBBBBBBB → rdata_o[0]=0xAAAAAAAA;
  - separately, rvalid with an empty FIFO → protocol_err_o=1 until rst_i.
